// File: rtl/mod3529_accum.sv
// Streaming accumulator: sums 12-bit beats and presents (sum mod 3529) on a ready/valid output.
// Build with MOD3529_ACCUM_OVF_EN to add the sticky ovf output.

module barret_for_3529 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);
  // Barrett: m = floor(2^24 / 3529) = 4754; the quotient estimate is low by at most one.
  logic [11:0] w_q;
  logic [13:0] w_r0;
  logic [13:0] w_r1;

  assign w_q    = 12'((36'(din_a) * 36'd4754) >> 24);
  assign w_r0   = 14'(24'(din_a) - 24'(w_q) * 24'd3529);
  assign w_r1   = (w_r0 >= 14'd3529) ? w_r0 - 14'd3529 : w_r0;
  assign dout_r = 12'((w_r1 >= 14'd3529) ? w_r1 - 14'd3529 : w_r1);
endmodule

module mod3529_accum #(
  parameter int MAX_BEATS = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data
`ifdef MOD3529_ACCUM_OVF_EN
  ,
  output logic        ovf
`endif
);

  if (MAX_BEATS < 1 || MAX_BEATS > 2047) begin : g_badParam
    $error("MAX_BEATS must lie in 1..2047 to fit the 11-bit counter and 23-bit sum");
  end

  typedef enum logic [1:0] {ACC, REDUCE, OUT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [22:0] r_acc;
  logic [10:0] r_cnt;
  logic        r_redPhase;
  logic [11:0] r_outData;
  logic        r_outValid;
  logic        w_accept;
  logic        w_take;
  logic [11:0] w_dout;

  barret_for_3529 u_reduce (
    .din_a  (r_acc),
    .dout_r (w_dout)
  );

  assign in_ready  = (r_state == ACC) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_take    = (r_state == OUT) && out_ready;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_nextState;
  end

  // REDUCE spans two edges so the result appears exactly two edges after the last beat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ACC:     if (w_accept && in_last) w_nextState = REDUCE;
      REDUCE:  if (r_redPhase) w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = ACC;
      default: w_nextState = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_redPhase <= 1'b0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= r_acc + {11'd0, in_data};
        r_cnt <= r_cnt + 11'd1;
      end
      if (r_state == REDUCE) begin
        r_redPhase <= ~r_redPhase;
        if (r_redPhase) begin
          r_outData  <= w_dout;
          r_outValid <= 1'b1;
        end
      end
      if (w_take) begin
        r_outValid <= 1'b0;
        r_acc      <= '0;
        r_cnt      <= '0;
      end
    end
  end

`ifdef MOD3529_ACCUM_OVF_EN
  localparam logic [10:0] CNT_MAX = 11'(MAX_BEATS);

  logic r_ovf;

  // Sticky until the result handshake so the consumer sees it alongside out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      if (w_accept && (r_cnt == CNT_MAX)) r_ovf <= 1'b1;
      if (w_take) r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_mod3529_accum.sv
// Directed bench for mod3529_accum: table of sequences plus hand-written reset/backpressure cases.

module tb_mod3529_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
`ifdef MOD3529_ACCUM_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    int          count;
    logic [11:0] value;
    logic [11:0] lastValue;
    logic [11:0] expData;
  } vec_t;

  vec_t vecs[7];

  mod3529_accum #(.MAX_BEATS(2047)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MOD3529_ACCUM_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // count-1 beats of value, then lastValue flagged as last; returns after the accepting edge.
  task automatic applyStimulus(input int count, input logic [11:0] value, input logic [11:0] lastValue);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i == count - 1) ? lastValue : value;
      in_last  = (i == count - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expectResult(input string name, input logic [11:0] expData, input bit doHandshake);
    checkOutput({name, "_lat0"}, 32'(out_valid), 32'd0);
    checkOutput({name, "_rdy0"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_data"}, 32'(out_data), 32'(expData));
    if (doHandshake) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({name, "_drop"}, 32'(out_valid), 32'd0);
      checkOutput({name, "_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"zero_sum",   2,    12'd3528, 12'd1,    12'd0};
    vecs[1] = '{"single_max", 1,    12'd0,    12'd4095, 12'd566};
    vecs[2] = '{"full_len",   2047, 12'd4095, 12'd4095, 12'd1090};
    vecs[3] = '{"five_beat",  5,    12'd1000, 12'd529,  12'd1000};
    vecs[4] = '{"all_zero",   2,    12'd0,    12'd0,    12'd0};
    vecs[5] = '{"modulus",    1,    12'd0,    12'd3529, 12'd0};
    vecs[6] = '{"mod_minus1", 1,    12'd0,    12'd3528, 12'd3528};

    #1;
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
`ifdef MOD3529_ACCUM_OVF_EN
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].count, vecs[v].value, vecs[v].lastValue);
`ifdef MOD3529_ACCUM_OVF_EN
      if (vecs[v].count == 2047) checkOutput("full_len_ovf", 32'(ovf), 32'd0);
`endif
      expectResult(vecs[v].name, vecs[v].expData, 1'b1);
    end

    // Idle gap mid-sequence must leave the partial sum untouched.
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'd50; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    applyStimulus(1, 12'd0, 12'd60);
    expectResult("idle_gap", 12'd110, 1'b1);

    // Backpressure: result held five cycles, an in_valid pulse meanwhile is ignored.
    applyStimulus(2, 12'd100, 12'd200);
    expectResult("hold", 12'd300, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      in_data  = 12'd4095;
      in_last  = (c == 2);
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", 32'(out_data), 32'd300);
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    applyStimulus(1, 12'd0, 12'd7);
    expectResult("after_hold", 12'd7, 1'b1);

    // Reset mid-accumulation discards the partial sum.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 12'(100 * (i + 1)); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 12'd0, 12'd7);
    expectResult("after_rst", 12'd7, 1'b1);

    // Reset while a result is pending drops it without a clock edge.
    applyStimulus(1, 12'd0, 12'd1234);
    expectResult("pending", 12'd1234, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("out_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("out_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("out_rst_ready", 32'(in_ready), 32'd1);
    applyStimulus(2, 12'd1, 12'd2);
    expectResult("after_out_rst", 12'd3, 1'b1);

`ifdef MOD3529_ACCUM_OVF_EN
    applyStimulus(2047, 12'd1, 12'd1);
    expectResult("max_ovf_clear", 12'd2047, 1'b0);
    checkOutput("max_ovf", 32'(ovf), 32'd0);
    handshake();
    applyStimulus(2048, 12'd1, 12'd1);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    expectResult("ovf_seq", 12'd2048, 1'b0);
    checkOutput("ovf_held", 32'(ovf), 32'd1);
    handshake();
    checkOutput("ovf_cleared", 32'(ovf), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod3529_accum.md
MOD3529_ACCUM -- requirements
Module: mod3529_accum

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 2047, giving the maximum beats per sequence for which the 23-bit raw sum is guaranteed exact (2047*4095 < 2^23).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data/in_last valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-006 SHALL have port in_data, input, 12 bits: unsigned operand, 0..4095.
REQ-007 SHALL have port in_last, input, 1 bit: final beat of a sequence.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port out_data, output, 12 bits: (sum of sequence) mod 3529, range 0..3528.
REQ-011 SHALL have port ovf, output, 1 bit, present only with MOD3529_ACCUM_OVF_EN (REQ-031).

Function
REQ-012 SHALL keep a 23-bit raw accumulator acc, an 11-bit beat counter cnt and a state register with states ACC, REDUCE and OUT.
REQ-013 SHALL count a beat as accepted when in_valid && in_ready at a rising edge.
REQ-014 SHALL drive in_ready = 1 only in ACC; in REDUCE and OUT it is 0 and in_valid is ignored.
REQ-015 SHALL, on an accepted beat: acc <= acc + in_data (23-bit, wraps modulo 2^23); cnt <= cnt + 1 (11-bit, wraps).
REQ-016 SHALL, on an accepted beat with in_last = 1, go ACC -> REDUCE; with in_last = 0, stay in ACC.
REQ-017 SHALL feed acc to the existing combinational reducer barret_for_3529 (din_a = acc, dout_r 12 bits), instantiated inside the block.
REQ-018 SHALL, in REDUCE: register out_data <= dout_r and out_valid <= 1 at the next edge, and go to OUT.
REQ-019 SHALL make latency from the edge accepting the last beat to out_valid high exactly 2 edges (edge N accepts, edge N+2 asserts out_valid).
REQ-020 SHALL, in OUT: hold out_valid and out_data stable while out_ready = 0.
REQ-021 SHALL, in OUT at an edge with out_ready = 1: out_valid <= 0, acc <= 0, cnt <= 0, go to ACC; in_ready is 1 from the following cycle.
REQ-022 SHALL, with no in_valid, stay in ACC with acc and cnt unchanged for any number of cycles.
REQ-023 SHALL treat a single-beat sequence (first beat has in_last = 1) normally: result = in_data mod 3529.
REQ-024 SHALL leave out_data at its previous value when out_valid = 0; consumers sample out_data only when out_valid = 1.

Reset
REQ-025 SHALL, with rst high, immediately and without a clock force state = ACC, acc = 0, cnt = 0, out_valid = 0, out_data = 0, ovf = 0.
REQ-026 SHALL hold in_ready at 0 while rst is high.
REQ-027 SHALL, on reset in any state (mid-accumulation, REDUCE, or OUT with a pending result), discard the partial sum and pending result with no output produced.
REQ-028 SHALL have in_ready = 1 on the first edge after rst falls.

Configuration
REQ-029 SHALL use the macro MOD3529_ACCUM_OVF_EN.
REQ-030 SHALL, without the macro: omit the ovf port; sequences longer than MAX_BEATS give acc modulo 2^23 reduced mod 3529, with no indication.
REQ-031 SHALL, with the macro: set ovf (sticky) at the edge accepting a beat while cnt == MAX_BEATS; clear ovf only by reset or the REQ-021 result handshake; keep all other behaviour identical.

Verification
REQ-032 SHALL cover: beats 3528, 1(last) -> out_data = 0, out_valid high exactly 2 edges after the last beat.
REQ-033 SHALL cover: single beat 4095(last) -> out_data = 566.
REQ-034 SHALL cover: 2047 beats of 4095, last on beat 2047 -> out_data = 1090; ovf = 0 with the macro.
REQ-035 SHALL cover: out_ready low 5 cycles after out_valid -> out_data and out_valid stable, in_ready = 0 throughout, and an in_valid pulse then is not accepted.
REQ-036 SHALL cover: rst pulse after 3 beats (100, 200, 300), then 7(last) -> out_data = 7.
REQ-037 SHALL cover, with the macro: 2048 beats of 1 -> ovf = 1 from beat 2048 onward, cleared by the result handshake.
